// File: rtl/idct_1d_8x1_seq_if.sv
// Valid/ready streaming bundle for the 8-point 1-D IDCT.
// The upstream stage drives in_valid/data_in and the downstream stage drives out_ready.
interface idct_1d_8x1_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [8*DATA_WIDTH-1:0]   data_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [8*DATA_WIDTH-1:0]   idct_out;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, idct_out
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, idct_out
    );
endinterface

// File: rtl/idct_1d_8x1_seq.sv
// Sequential 8-point 1-D IDCT: f(x) = sum_u C[u][x]*F(u), one u per cycle on 8 MAC lanes.
// Optional macro IDCT_ROUND_EN selects round-half-up instead of floor on the final shift.
module idct_1d_8x1_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_WIDTH*64-1:0]   coeff_vector,
    idct_1d_8x1_seq_if.slave           bus
);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W  = 2 * DATA_WIDTH + 3;
    localparam int EXT_W  = ACC_W + 1;

    localparam logic signed [EXT_W-1:0] SAT_MAX =
        {{(EXT_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN =
        {{(EXT_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`ifdef IDCT_ROUND_EN
    localparam logic signed [EXT_W-1:0] RND =
        {{(EXT_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic [2:0]                     r_k;
    logic signed [DATA_WIDTH-1:0]   r_f   [8];
    logic signed [ACC_W-1:0]        r_acc [8];
    logic [8*DATA_WIDTH-1:0]        r_out;

    logic signed [DATA_WIDTH-1:0]   w_fk;
    logic signed [DATA_WIDTH-1:0]   w_coef [8];
    logic signed [PROD_W-1:0]       w_prod [8];
    logic signed [ACC_W-1:0]        w_sum  [8];
    logic [8*DATA_WIDTH-1:0]        w_res;

    // One guard bit above the accumulator keeps the rounding add from wrapping.
    function automatic logic [DATA_WIDTH-1:0] scale_sat(input logic signed [ACC_W-1:0] a);
        logic signed [EXT_W-1:0] t;
        t = EXT_W'(a);
`ifdef IDCT_ROUND_EN
        t = t + RND;
`endif
        t = t >>> FRAC_BITS;
        if (t > SAT_MAX)
            scale_sat = SAT_MAX[DATA_WIDTH-1:0];
        else if (t < SAT_MIN)
            scale_sat = SAT_MIN[DATA_WIDTH-1:0];
        else
            scale_sat = t[DATA_WIDTH-1:0];
    endfunction

    // Lane x uses row k of the basis (C[k][x]), i.e. the transpose of the forward DCT.
    always_comb begin
        w_fk  = r_f[r_k];
        w_res = '0;
        for (int x = 0; x < 8; x++) begin
            w_coef[x] = coeff_vector[(int'(r_k) * 8 + x) * DATA_WIDTH +: DATA_WIDTH];
            w_prod[x] = PROD_W'(w_coef[x]) * PROD_W'(w_fk);
            w_sum[x]  = r_acc[x] + ACC_W'(w_prod[x]);
            w_res[x*DATA_WIDTH +: DATA_WIDTH] = scale_sat(w_sum[x]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_next = S_ACCUM;
            S_ACCUM: if (r_k == 3'd7)   w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == S_IDLE) && !reset;
        bus.out_valid = (r_state == S_DONE);
        bus.idct_out  = r_out;
    end

    // The last MAC result is scaled straight into the output register on DONE entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k   <= '0;
            r_out <= '0;
            for (int x = 0; x < 8; x++) r_acc[x] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_k <= '0;
                        for (int x = 0; x < 8; x++) begin
                            r_acc[x] <= '0;
                            r_f[x]   <= bus.data_in[x*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
                S_ACCUM: begin
                    r_k <= r_k + 3'd1;
                    for (int x = 0; x < 8; x++) r_acc[x] <= w_sum[x];
                    if (r_k == 3'd7) r_out <= w_res;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_idct_1d_8x1_seq.sv
// Directed scoreboard bench for idct_1d_8x1_seq (DATA_WIDTH=32, FRAC_BITS=16).
module tb_idct_1d_8x1_seq;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DW*64-1:0]  coeff_vector;

    idct_1d_8x1_seq_if #(.DATA_WIDTH(DW)) bus();

    idct_1d_8x1_seq #(.DATA_WIDTH(DW), .FRAC_BITS(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .coeff_vector (coeff_vector),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [255:0] sb[$];
    logic signed [31:0] cm [8][8];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_coef();
        for (int u = 0; u < 8; u++)
            for (int x = 0; x < 8; x++)
                coeff_vector[(u*8+x)*32 +: 32] = cm[u][x];
    endtask

    function automatic logic [255:0] rep(input logic [31:0] v);
        return {8{v}};
    endfunction

    // Reference: wide exact sum, then shift/round and clamp.
    function automatic logic [255:0] model(input logic [255:0] f);
        logic [255:0] r;
        logic signed [127:0] s;
        logic signed [127:0] a;
        logic signed [127:0] b;
        r = '0;
        for (int x = 0; x < 8; x++) begin
            s = '0;
            for (int u = 0; u < 8; u++) begin
                a = 128'(cm[u][x]);
                b = 128'($signed(f[u*32 +: 32]));
                s = s + a * b;
            end
`ifdef IDCT_ROUND_EN
            s = s + 128'sd32768;
`endif
            s = s >>> 16;
            if (s > 128'sh7FFFFFFF)        r[x*32 +: 32] = 32'h7FFFFFFF;
            else if (s < -128'sh80000000)  r[x*32 +: 32] = 32'h80000000;
            else                           r[x*32 +: 32] = s[31:0];
        end
        return r;
    endfunction

    task automatic start(input logic [255:0] f);
        bus.data_in  = f;
        bus.in_valid = 1'b1;
        check("in_ready_at_offer", 256'(bus.in_ready), 256'(1));
        sb.push_back(model(f));
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int cyc;
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 256'(cyc), 256'(8));
    endtask

    task automatic finish(input string tag, output logic [255:0] got);
        wait_out(tag);
        got = bus.idct_out;
        check({tag, "_sb_nonempty"}, 256'(sb.size() > 0), 256'(1));
        if (sb.size() > 0) check(tag, got, sb.pop_front());
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_ov_drop"}, 256'(bus.out_valid), 256'(0));
        check({tag, "_in_ready_back"}, 256'(bus.in_ready), 256'(1));
    endtask

    task automatic set_identity();
        for (int u = 0; u < 8; u++)
            for (int x = 0; x < 8; x++)
                cm[u][x] = (u == x) ? 32'sh00010000 : 32'sh0;
        load_coef();
    endtask

    initial begin
        logic [255:0] got;
        logic [255:0] fid;
        logic [255:0] frnd;
        logic [255:0] bp_exp;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.data_in   = '0;
        for (int u = 0; u < 8; u++) fid[u*32 +: 32] = 32'h00010000 * (u + 1);
        set_identity();

        repeat (3) tick();
        check("reset_in_ready", 256'(bus.in_ready), 256'(0));
        check("reset_out_valid", 256'(bus.out_valid), 256'(0));
        check("reset_idct_out", bus.idct_out, 256'(0));
        reset = 1'b0;
        #1;
        check("post_reset_in_ready", 256'(bus.in_ready), 256'(1));

        start(fid);
        finish("identity", got);
        check("identity_eq_in", got, fid);

        for (int u = 0; u < 8; u++)
            for (int x = 0; x < 8; x++) cm[u][x] = 32'sh00010000;
        load_coef();
        start(rep(32'h00010000));
        finish("ones_pos", got);
        check("ones_pos_const", got, rep(32'h00080000));
        start(rep(32'hFFFF0000));
        finish("ones_neg", got);
        check("ones_neg_const", got, rep(32'hFFF80000));
        start(rep(32'h7FFFFFFF));
        finish("sat_pos", got);
        check("sat_pos_const", got, rep(32'h7FFFFFFF));
        start(rep(32'h80000000));
        finish("sat_neg", got);
        check("sat_neg_const", got, rep(32'h80000000));

        for (int u = 0; u < 8; u++)
            for (int x = 0; x < 8; x++) cm[u][x] = (u == 0) ? 32'sh00008000 : 32'sh0;
        load_coef();
        start({224'b0, 32'h00000001});
        finish("round_p1", got);
`ifdef IDCT_ROUND_EN
        check("round_p1_const", got, rep(32'h00000001));
`else
        check("round_p1_const", got, rep(32'h00000000));
`endif
        start({224'b0, 32'hFFFFFFFF});
        finish("round_m1", got);
`ifdef IDCT_ROUND_EN
        check("round_m1_const", got, rep(32'h00000000));
`else
        check("round_m1_const", got, rep(32'hFFFFFFFF));
`endif

        for (int u = 0; u < 8; u++)
            for (int x = 0; x < 8; x++) cm[u][x] = $signed($urandom_range(0, 32'h40000)) - 32'sh20000;
        load_coef();
        for (int u = 0; u < 8; u++) frnd[u*32 +: 32] = $urandom_range(0, 32'h200000) - 32'h100000;
        start(frnd);
        finish("random", got);

        set_identity();
        start(fid);
        wait_out("bp");
        bp_exp = sb[0];
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = (i == 10);
            bus.data_in  = rep(32'h12345678);
            check("bp_out_valid", 256'(bus.out_valid), 256'(1));
            check("bp_idct_out", bus.idct_out, bp_exp);
            check("bp_in_ready", 256'(bus.in_ready), 256'(0));
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        void'(sb.pop_front());
        check("bp_release_ov", 256'(bus.out_valid), 256'(0));
        repeat (12) tick();
        check("bp_single_transfer_ov", 256'(bus.out_valid), 256'(0));
        check("bp_single_transfer_ir", 256'(bus.in_ready), 256'(1));

        start(fid);
        wait_out("overlap");
        check("overlap_out", bus.idct_out, sb.pop_front());
        bus.in_valid  = 1'b1;
        bus.data_in   = rep(32'h00020000);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("overlap_not_taken_ov", 256'(bus.out_valid), 256'(0));
        start(rep(32'h00020000));
        finish("overlap_next", got);

        bus.data_in  = fid;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("midreset_out_valid", 256'(bus.out_valid), 256'(0));
        check("midreset_idct_out", bus.idct_out, 256'(0));
        reset = 1'b0;
        #1;
        check("midreset_in_ready", 256'(bus.in_ready), 256'(1));
        start(fid);
        finish("post_reset_identity", got);
        check("post_reset_identity_eq_in", got, fid);

        check("sb_drained", 256'(sb.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
